intensity_xform_stream: RTL



---
 rtl/intensity_pkg.sv | 14 +
 rtl/intensity_lut.sv | 22 ++
 rtl/intensity_xform_stream.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/intensity_pkg.sv
// intensity_pkg: shared mode/state encodings and the saturation helper for the intensity transform
package intensity_pkg;
   typedef enum logic [1:0] {
      MODE_LINEAR = 2'b00,
      MODE_LUT    = 2'b01,
      MODE_NEG    = 2'b10,
      MODE_THRESH = 2'b11
   } mode_t;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   // Clamp a signed intermediate into [0, max]
   function automatic logic [31:0] saturate(input logic signed [31:0] s, input logic [31:0] max);
      return (s < 0) ? 32'd0 : (s > signed'(max)) ? max : unsigned'(s);
   endfunction
endpackage

// File: rtl/intensity_lut.sv
// intensity_lut: synchronous-write, registered-read lookup table shaped for block RAM
module intensity_lut
   import intensity_pkg::*;
#(
   parameter int PIX_W = 8
) (
   input  logic             clock,
   input  logic             we,
   input  logic [PIX_W-1:0] waddr,
   input  logic [PIX_W-1:0] wdata,
   input  logic             re,
   input  logic [PIX_W-1:0] raddr,
   output logic [PIX_W-1:0] rdata
);
   logic [PIX_W-1:0] mem [0:(1<<PIX_W)-1];
   // write port; contents survive reset
   always_ff @(posedge clock)
      if (we) mem[waddr] <= wdata;
   // read register advances with the pipeline enable so it holds during stalls
   always_ff @(posedge clock)
      if (re) rdata <= mem[raddr];
endmodule

// File: rtl/intensity_xform_stream.sv
// intensity_xform_stream: streaming per-pixel intensity transform with row/frame tagging
module intensity_xform_stream
   import intensity_pkg::*;
#(
   parameter int PIX_W     = 8,
   parameter int ROW_LEN   = 320,
   parameter int NUM_ROWS  = 240,
   parameter int GAIN_W    = 8,
   parameter int GAIN_FRAC = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [GAIN_W-1:0] gain,
   input  logic [PIX_W:0]    offset,
   input  logic [PIX_W-1:0]  thresh,
   input  logic              lut_we,
   input  logic [PIX_W-1:0]  lut_addr,
   input  logic [PIX_W-1:0]  lut_wdata,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PIX_W-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PIX_W-1:0]  out_data,
   output logic              out_eol,
   output logic              out_eof,
   output logic              busy,
   output logic              done
);
   localparam int P_W = PIX_W + GAIN_W;
   localparam int S_W = P_W + 2;
   localparam int C_W = ROW_LEN > 1 ? $clog2(ROW_LEN) : 1;
   localparam int R_W = NUM_ROWS > 1 ? $clog2(NUM_ROWS) : 1;
   localparam logic [31:0] MAX = 32'((1 << PIX_W) - 1);
   state_t state_q, state_d;
   mode_t cfg_mode;
   logic [GAIN_W-1:0] cfg_gain;
   logic [PIX_W:0] cfg_offset;
   logic [PIX_W-1:0] cfg_thresh;
   logic [C_W-1:0] col;
   logic [R_W-1:0] row;
   logic en, accept, eol_in, eof_in, launch;
   logic v1, eol1, eof1;
   logic [P_W-1:0] p1, t;
   logic [PIX_W-1:0] d1, lut_q, res;
   logic signed [S_W-1:0] s;
   logic [31:0] clamped;
   logic sat_unused;
   assign en       = !out_valid || out_ready;
   assign in_ready = (state_q == RUN) && en;
   assign accept   = in_valid && in_ready;
   assign launch   = (state_q == IDLE) && start;
   assign eol_in   = col == C_W'(ROW_LEN - 1);
   assign eof_in   = eol_in && (row == R_W'(NUM_ROWS - 1));
   assign busy     = (state_q == RUN) || (state_q == DRAIN);
   assign done     = state_q == DONE;
   // frame sequencing: IDLE -> RUN -> DRAIN -> DONE -> IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  state_d = start ? RUN : IDLE;
         RUN:   state_d = (accept && eof_in) ? DRAIN : RUN;
         DRAIN: state_d = (out_valid && out_ready && out_eof) ? DONE : DRAIN;
         DONE:  state_d = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clock)
      if (!reset) state_q <= IDLE;
      else state_q <= state_d;
   // configuration is captured once per frame so port changes mid-frame are harmless
   always_ff @(posedge clock)
      if (!reset) begin
         cfg_mode   <= MODE_LINEAR;
         cfg_gain   <= '0;
         cfg_offset <= '0;
         cfg_thresh <= '0;
      end else if (launch) begin
         cfg_mode   <= mode_t'(mode);
         cfg_gain   <= gain;
         cfg_offset <= offset;
         cfg_thresh <= thresh;
      end
   // column/row position of the next accepted pixel
   always_ff @(posedge clock)
      if (!reset || launch) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         col <= eol_in ? '0 : col + C_W'(1);
         row <= eof_in ? '0 : eol_in ? row + R_W'(1) : row;
      end
   intensity_lut #(.PIX_W(PIX_W)) u_lut (
      .clock (clock),
      .we    (lut_we && (state_q == IDLE)),
      .waddr (lut_addr),
      .wdata (lut_wdata),
      .re    (en),
      .raddr (in_data),
      .rdata (lut_q)
   );
   // stage 1: product (LUT read lives in u_lut), raw pixel and tags
   always_ff @(posedge clock)
      if (!reset) begin
         v1   <= 1'b0;
         p1   <= '0;
         d1   <= '0;
         eol1 <= 1'b0;
         eof1 <= 1'b0;
      end else if (en) begin
         v1   <= accept;
         p1   <= P_W'(in_data) * P_W'(cfg_gain);
         d1   <= in_data;
         eol1 <= eol_in;
         eof1 <= eof_in;
      end
   assign t          = p1 >> GAIN_FRAC;
   assign s          = signed'({2'b00, t}) + S_W'(signed'(cfg_offset));
   assign clamped    = saturate(32'(s), MAX);
   assign sat_unused = ^clamped[31:PIX_W];
   assign res = (cfg_mode == MODE_LUT)    ? lut_q :
                (cfg_mode == MODE_NEG)    ? ~d1 :
                (cfg_mode == MODE_THRESH) ? {PIX_W{d1 >= cfg_thresh}} :
                clamped[PIX_W-1:0];
   // stage 2: output register; data only moves with a real pixel so it stays clean after reset
   always_ff @(posedge clock)
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
      end else if (en) begin
         out_valid <= v1;
         if (v1) begin
            out_data <= res;
            out_eol  <= eol1;
            out_eof  <= eof1;
         end
      end
endmodule
